// File: rtl/instr_fetch.sv
// Instruction fetch stage: one req/gnt/rvalid memory transaction per PC, decoder valid/ready
// handoff, then a one-cycle pc_step. Misalignment, bus errors and timeouts park in a sticky FAULT.
module instr_fetch #(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_err,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            dec_ready,
   output logic            pc_step,
   output logic            fault,
   output logic [1:0]      fault_cause,
   input  logic            fault_clr
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, STEP, FAULT} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt;
   logic [1:0]    cause_d;
   logic          tmo;

   assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_d = state;
      cause_d = 2'b00;
      case (state)
         IDLE:  if (pc[1:0] != 2'b00) begin
                   state_d = FAULT;
                   cause_d = 2'b01;
                end else begin
                   state_d = REQ;
                end
         REQ:   if (imem_gnt) state_d = WAIT;
         // a response in the timeout cycle still counts
         WAIT:  if (imem_rvalid) begin
                   if (imem_err) begin
                      state_d = FAULT;
                      cause_d = 2'b10;
                   end else begin
                      state_d = HOLD;
                   end
                end else if (tmo) begin
                   state_d = FAULT;
                   cause_d = 2'b11;
                end
         HOLD:  if (dec_ready) state_d = STEP;
         STEP:  state_d = IDLE;
         FAULT: if (fault_clr) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imem_addr   <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         cnt         <= '0;
         fault_cause <= 2'b00;
      end else begin
         if (state == IDLE && pc[1:0] == 2'b00) imem_addr <= pc;
         if (state == REQ && imem_gnt) cnt <= '0;
         else if (state == WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
         if (state == WAIT && imem_rvalid && !imem_err) begin
            instr    <= imem_rdata;
            instr_pc <= imem_addr;
         end
         if (state != FAULT && state_d == FAULT) fault_cause <= cause_d;
         else if (state == FAULT && fault_clr)   fault_cause <= 2'b00;
      end
   end

   assign imem_req    = (state == REQ);
   assign instr_valid = (state == HOLD);
   assign pc_step     = (state == STEP);
   assign fault       = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected grants, instructions, steps and
// faults; a negedge monitor pops and compares whenever the DUT presents one of them.
module tb_instr_fetch;

   localparam int K_REQ = 0, K_INSTR = 1, K_STEP = 2, K_FAULT = 3;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   logic        clk = 0, rst = 0;
   logic [31:0] pc = 0, imem_addr, imem_rdata = 0, instr, instr_pc;
   logic        imem_req, imem_gnt = 0, imem_rvalid = 0, imem_err = 0;
   logic        instr_valid, dec_ready = 0, pc_step, fault, fault_clr = 0;
   logic [1:0]  fault_cause;

   exp_t q[$];
   int   total = 0, passed = 0;
   logic fault_q = 0;

   instr_fetch #(.TIMEOUT(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .pc(pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .dec_ready(dec_ready), .pc_step(pc_step),
      .fault(fault), .fault_cause(fault_cause), .fault_clr(fault_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
      else passed++;
   endtask

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.kind = k; e.a = a; e.b = b;
      q.push_back(e);
   endtask

   task automatic pop(input int k, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         $display("FAIL unexpected_event: got kind %0d a=%h, want none", k, a);
      end else begin
         e = q.pop_front();
         chk("event_kind", k, e.kind);
         chk("event_a", a, e.a);
         chk("event_b", b, e.b);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (imem_req && imem_gnt) pop(K_REQ, imem_addr, 0);
         if (instr_valid && dec_ready) pop(K_INSTR, instr, instr_pc);
         if (pc_step) pop(K_STEP, 0, 0);
         if (fault && !fault_q) pop(K_FAULT, {30'd0, fault_cause}, 0);
         fault_q = fault;
      end else begin
         fault_q = 0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 10) begin tick(); n++; end
      chk("req_seen", imem_req, 1);
   endtask

   // gd: grant withheld cycles, rd: WAIT cycles before rvalid, dd: decoder stall cycles
   task automatic fetch(input logic [31:0] p, input int gd, input int rd, input logic [31:0] d,
                        input logic e, input int dd, output int reqc, output int vldc);
      push(K_REQ, p, 0);
      wait_req();
      reqc = 0;
      repeat (gd) begin
         if (imem_req) reqc++;
         chk("addr_stable", imem_addr, p);
         pc = p ^ 32'h100;
         tick();
      end
      if (imem_req) reqc++;
      imem_gnt = 1; tick(); imem_gnt = 0; pc = p;
      repeat (rd) tick();
      imem_rvalid = 1; imem_rdata = d; imem_err = e;
      if (e) push(K_FAULT, 2, 0);
      else begin push(K_INSTR, d, p); push(K_STEP, 0, 0); end
      tick();
      imem_rvalid = 0; imem_err = 0;
      vldc = 0;
      if (!e) begin
         repeat (dd) begin
            if (instr_valid) vldc++;
            chk("instr_stable", instr, d);
            chk("no_step_stalled", pc_step, 0);
            tick();
         end
         if (instr_valid) vldc++;
         dec_ready = 1; tick(); dec_ready = 0;
         chk("step_pulse", pc_step, 1);
         chk("valid_drop", instr_valid, 0);
         pc = p + 4;
         tick();
         chk("step_one_cycle", pc_step, 0);
      end
   endtask

   task automatic clear(input logic [31:0] np);
      fault_clr = 1; pc = np; tick(); fault_clr = 0;
      chk("fault_cleared", fault, 0);
      chk("cause_cleared", fault_cause, 0);
   endtask

   task automatic wait_fault();
      int n = 0;
      while (!fault && n < 10) begin
         chk("no_req_fault_path", imem_req, 0);
         tick(); n++;
      end
      chk("fault_seen", fault, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"}, {imem_req, instr_valid, pc_step, fault, fault_cause}, 0);
      chk({tag, "_addr"}, imem_addr, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_ipc"}, instr_pc, 0);
   endtask

   initial begin
      int rc, vc, n;
      #2 chk_zero("reset");
      tick(); rst = 1;

      // normal fetch, then the next pc
      fetch(32'h0, 0, 0, 32'h00A00093, 0, 0, rc, vc);
      chk("norm_reqc", rc, 1);
      chk("norm_vld", vc, 1);
      fetch(32'h4, 0, 0, 32'h00100113, 0, 0, rc, vc);

      // grant and decoder backpressure
      pc = 32'h10;
      fetch(32'h10, 3, 0, 32'h12345678, 0, 4, rc, vc);
      chk("bp_reqc", rc, 4);
      chk("bp_vld", vc, 5);

      // misaligned pc
      pc = 32'h6;
      push(K_FAULT, 1, 0);
      wait_fault();
      repeat (2) begin
         tick();
         chk("mis_sticky", {fault, fault_cause}, 3'b101);
         chk("mis_no_step", pc_step, 0);
      end
      clear(32'h8);
      fetch(32'h8, 0, 0, 32'h11111111, 0, 0, rc, vc);

      // bus error
      fetch(32'hC, 0, 1, 32'hDEADBEEF, 1, 0, rc, vc);
      repeat (3) begin
         chk("err_no_valid", instr_valid, 0);
         chk("err_no_step", pc_step, 0);
         chk("err_cause", fault_cause, 2);
         tick();
      end
      clear(32'h20);

      // timeout after exactly 4 WAIT cycles
      push(K_REQ, 32'h20, 0);
      wait_req();
      imem_gnt = 1; tick(); imem_gnt = 0;
      push(K_FAULT, 3, 0);
      n = 0;
      while (!fault && n < 20) begin tick(); n++; end
      chk("tmo_wait_cycles", n, 4);
      clear(32'h24);

      // rvalid on the final WAIT cycle wins over the timeout
      fetch(32'h24, 0, 3, 32'hCAFEF00D, 0, 0, rc, vc);
      chk("tmo_edge_vld", vc, 1);

      // reset mid-transaction with a stale response afterwards
      pc = 32'h30;
      push(K_REQ, 32'h30, 0);
      wait_req();
      imem_gnt = 1; tick(); imem_gnt = 0;
      rst = 0; #1;
      chk_zero("midrst");
      tick(); rst = 1;
      tick();
      imem_rvalid = 1; imem_rdata = 32'hBADBAD00;
      tick(); imem_rvalid = 0;
      chk("stale_no_valid", instr_valid, 0);
      chk("stale_instr", instr, 0);
      fetch(32'h30, 0, 0, 32'h00000013, 0, 0, rc, vc);

      repeat (3) tick();
      chk("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
